// File: rtl/ysyx_22041071_axi_w_arb_if.sv
// Bundle of the two requester ports, the write-engine command port and arbiter status.
// The arbiter uses the slave modport; the requesters and engine side use master.
interface ysyx_22041071_axi_w_arb_if #(
    parameter int unsigned ID_W   = 4,
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned LEN_W  = 8
);
    logic              req0_valid;
    logic [ID_W-1:0]   req0_id;
    logic [ADDR_W-1:0] req0_addr;
    logic [LEN_W-1:0]  req0_len;
    logic [1:0]        req0_size;
    logic [DATA_W-1:0] req0_wdata;
    logic              req0_ready;
    logic              req0_done;
    logic [1:0]        req0_resp;

    logic              req1_valid;
    logic [ID_W-1:0]   req1_id;
    logic [ADDR_W-1:0] req1_addr;
    logic [LEN_W-1:0]  req1_len;
    logic [1:0]        req1_size;
    logic [DATA_W-1:0] req1_wdata;
    logic              req1_ready;
    logic              req1_done;
    logic [1:0]        req1_resp;

    logic              eng_aw_valid;
    logic [ID_W-1:0]   eng_id;
    logic [ADDR_W-1:0] eng_addr;
    logic [LEN_W-1:0]  eng_len;
    logic [1:0]        eng_size;
    logic [DATA_W-1:0] eng_wdata;
    logic              eng_aw_ready;
    logic [1:0]        eng_w_resp;

    logic              busy;
    logic              grant;

    modport slave (
        input  req0_valid, req0_id, req0_addr, req0_len, req0_size, req0_wdata,
        output req0_ready, req0_done, req0_resp,
        input  req1_valid, req1_id, req1_addr, req1_len, req1_size, req1_wdata,
        output req1_ready, req1_done, req1_resp,
        output eng_aw_valid, eng_id, eng_addr, eng_len, eng_size, eng_wdata,
        input  eng_aw_ready, eng_w_resp,
        output busy, grant
    );

    modport master (
        output req0_valid, req0_id, req0_addr, req0_len, req0_size, req0_wdata,
        input  req0_ready, req0_done, req0_resp,
        output req1_valid, req1_id, req1_addr, req1_len, req1_size, req1_wdata,
        input  req1_ready, req1_done, req1_resp,
        input  eng_aw_valid, eng_id, eng_addr, eng_len, eng_size, eng_wdata,
        output eng_aw_ready, eng_w_resp,
        input  busy, grant
    );
endinterface

// File: rtl/ysyx_22041071_axi_w_arb.sv
// Two-requester write arbiter in front of the AXI write engine (req0 = D-cache writeback,
// req1 = uncached store). Define YSYX_22041071_WARB_FIXED_PRIO_EN for fixed req0 priority.
module ysyx_22041071_axi_w_arb #(
    parameter int unsigned ID_W   = 4,
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned LEN_W  = 8
) (
    input logic                           clk,
    input logic                           reset_n,
    ysyx_22041071_axi_w_arb_if.slave      bus
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY, S_DONE} state_e;

    state_e state_q, state_d;
    logic   last_q;
    logic   grant_q;
    logic   sel;
    logic   take;

    logic [ID_W-1:0]   win_id;
    logic [ADDR_W-1:0] win_addr;
    logic [LEN_W-1:0]  win_len;
    logic [1:0]        win_size;
    logic [DATA_W-1:0] win_wdata;

    logic [ID_W-1:0]   eng_id_q;
    logic [ADDR_W-1:0] eng_addr_q;
    logic [LEN_W-1:0]  eng_len_q;
    logic [1:0]        eng_size_q;
    logic [DATA_W-1:0] eng_wdata_q;
    logic [1:0]        resp0_q;
    logic [1:0]        resp1_q;

    // sel: 0 picks req0, 1 picks req1; only meaningful while some request is valid.
    always_comb begin
        sel = !bus.req0_valid;
`ifndef YSYX_22041071_WARB_FIXED_PRIO_EN
        if (bus.req0_valid && bus.req1_valid) begin
            sel = !last_q;
        end
`endif
    end

    always_comb begin
        win_id    = sel ? bus.req1_id    : bus.req0_id;
        win_addr  = sel ? bus.req1_addr  : bus.req0_addr;
        win_len   = sel ? bus.req1_len   : bus.req0_len;
        win_size  = sel ? bus.req1_size  : bus.req0_size;
        win_wdata = sel ? bus.req1_wdata : bus.req0_wdata;
    end

    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.req0_valid || bus.req1_valid) begin
                    take    = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.eng_aw_ready) begin
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (bus.eng_aw_ready) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Command stays latched until the next grant; the engine re-reads it every beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q      <= 1'b1;
            grant_q     <= 1'b0;
            eng_id_q    <= '0;
            eng_addr_q  <= '0;
            eng_len_q   <= '0;
            eng_size_q  <= '0;
            eng_wdata_q <= '0;
        end else if (take) begin
            last_q      <= sel;
            grant_q     <= sel;
            eng_id_q    <= win_id;
            eng_addr_q  <= win_addr;
            eng_len_q   <= win_len;
            eng_size_q  <= win_size;
            eng_wdata_q <= win_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp0_q <= 2'b00;
            resp1_q <= 2'b00;
        end else if (state_q == S_BUSY && bus.eng_aw_ready) begin
            if (grant_q) begin
                resp1_q <= bus.eng_w_resp;
            end else begin
                resp0_q <= bus.eng_w_resp;
            end
        end
    end

    assign bus.req0_ready   = take && !sel;
    assign bus.req1_ready   = take && sel;
    assign bus.req0_done    = (state_q == S_DONE) && !grant_q;
    assign bus.req1_done    = (state_q == S_DONE) && grant_q;
    assign bus.req0_resp    = resp0_q;
    assign bus.req1_resp    = resp1_q;
    assign bus.eng_aw_valid = (state_q == S_ISSUE);
    assign bus.eng_id       = eng_id_q;
    assign bus.eng_addr     = eng_addr_q;
    assign bus.eng_len      = eng_len_q;
    assign bus.eng_size     = eng_size_q;
    assign bus.eng_wdata    = eng_wdata_q;
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.grant        = grant_q;

endmodule

// File: tb/tb_ysyx_22041071_axi_w_arb.sv
// Directed bench for the write arbiter; the engine side is driven step by step.
module tb_ysyx_22041071_axi_w_arb;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic exp_g;
    logic [63:0] exp_addr;

    always #5 clk = ~clk;

    ysyx_22041071_axi_w_arb_if bus ();

    ysyx_22041071_axi_w_arb dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.req0_valid   = 1'b0;
        bus.req0_id      = '0;
        bus.req0_addr    = '0;
        bus.req0_len     = '0;
        bus.req0_size    = '0;
        bus.req0_wdata   = '0;
        bus.req1_valid   = 1'b0;
        bus.req1_id      = '0;
        bus.req1_addr    = '0;
        bus.req1_len     = '0;
        bus.req1_size    = '0;
        bus.req1_wdata   = '0;
        bus.eng_aw_ready = 1'b1;
        bus.eng_w_resp   = 2'b00;
    endtask

    // Starts in S_ISSUE with the engine idle; ends right after the edge into S_DONE.
    task automatic engine_run(input logic [1:0] resp, input int unsigned hold,
                              input logic [63:0] addr);
        tick();
        bus.eng_aw_ready = 1'b0;
        chk("aw_valid_drop", bus.eng_aw_valid, 1'b0);
        chk("busy_addr", bus.eng_addr, addr);
        for (int k = 0; k < int'(hold); k++) begin
            tick();
            chk("hold_addr", bus.eng_addr, addr);
            chk("hold_nodone", bus.req0_done | bus.req1_done, 1'b0);
        end
        bus.eng_w_resp   = resp;
        bus.eng_aw_ready = 1'b1;
        tick();
    endtask

    initial begin
        idle_inputs();
        reset_n = 1'b0;
        repeat (3) tick();
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_grant", bus.grant, 1'b0);
        chk("rst_awvalid", bus.eng_aw_valid, 1'b0);
        chk("rst_addr", bus.eng_addr, 64'h0);
        chk("rst_resp0", bus.req0_resp, 2'b00);
        chk("rst_resp1", bus.req1_resp, 2'b00);
        chk("rst_done", {bus.req0_done, bus.req1_done}, 2'b00);
        reset_n = 1'b1;
        tick();

        // Single req0 write, engine busy for 4 cycles.
        bus.req0_valid = 1'b1;
        bus.req0_id    = 4'h3;
        bus.req0_addr  = 64'h8000_0010;
        bus.req0_size  = 2'b10;
        bus.req0_len   = 8'd0;
        bus.req0_wdata = 64'hDEAD_BEEF;
        #1;
        chk("t1_ready0", bus.req0_ready, 1'b1);
        chk("t1_ready1", bus.req1_ready, 1'b0);
        tick();
        bus.req0_valid = 1'b0;
        bus.req0_addr  = 64'h1234;
        chk("t1_ready0_off", bus.req0_ready, 1'b0);
        chk("t1_awvalid", bus.eng_aw_valid, 1'b1);
        chk("t1_addr", bus.eng_addr, 64'h8000_0010);
        chk("t1_size", bus.eng_size, 2'b10);
        chk("t1_len", bus.eng_len, 8'd0);
        chk("t1_wdata", bus.eng_wdata, 64'hDEAD_BEEF);
        chk("t1_id", bus.eng_id, 4'h3);
        chk("t1_busy", bus.busy, 1'b1);
        chk("t1_grant", bus.grant, 1'b0);
        engine_run(2'b00, 4, 64'h8000_0010);
        chk("t1_done0", bus.req0_done, 1'b1);
        chk("t1_resp0", bus.req0_resp, 2'b00);
        chk("t1_done1", bus.req1_done, 1'b0);
        chk("t1_resp1", bus.req1_resp, 2'b00);
        tick();
        chk("t1_done0_off", bus.req0_done, 1'b0);
        chk("t1_idle", bus.busy, 1'b0);
        chk("t1_addr_kept", bus.eng_addr, 64'h8000_0010);

        // Fresh reset so `last` favours req0, then 4 contended transactions.
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        tick();
        bus.req0_addr  = 64'hA000;
        bus.req1_addr  = 64'hB000;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
`ifdef YSYX_22041071_WARB_FIXED_PRIO_EN
            exp_g = 1'b0;
`else
            exp_g = (i % 2) == 1;
`endif
            exp_addr = exp_g ? 64'hB000 : 64'hA000;
            #1;
            chk("rr_ready0", bus.req0_ready, !exp_g);
            chk("rr_ready1", bus.req1_ready, exp_g);
            tick();
            chk("rr_grant", bus.grant, exp_g);
            chk("rr_addr", bus.eng_addr, exp_addr);
            engine_run(2'b01, 1, exp_addr);
            chk("rr_done0", bus.req0_done, !exp_g);
            chk("rr_done1", bus.req1_done, exp_g);
            if (i == 3) begin
                bus.req0_valid = 1'b0;
                bus.req1_valid = 1'b0;
            end
            tick();
        end

        // req1 burst len=3, drops valid and changes addr after ready, engine SLVERR.
        bus.req1_valid = 1'b1;
        bus.req1_addr  = 64'h9000_0040;
        bus.req1_len   = 8'd3;
        bus.req1_size  = 2'b11;
        #1;
        chk("t3_ready1", bus.req1_ready, 1'b1);
        chk("t3_ready0", bus.req0_ready, 1'b0);
        tick();
        bus.req1_valid = 1'b0;
        bus.req1_addr  = 64'hFFFF_0000;
        chk("t3_addr", bus.eng_addr, 64'h9000_0040);
        chk("t3_len", bus.eng_len, 8'd3);
        chk("t3_grant", bus.grant, 1'b1);
        engine_run(2'b10, 2, 64'h9000_0040);
        chk("t3_done1", bus.req1_done, 1'b1);
        chk("t3_resp1", bus.req1_resp, 2'b10);
        chk("t3_done0", bus.req0_done, 1'b0);
        chk("t3_resp0_kept", bus.req0_resp, 2'b01);
        tick();
        chk("t3_done1_once_a", bus.req1_done, 1'b0);
        tick();
        chk("t3_done1_once_b", bus.req1_done, 1'b0);
        chk("t3_idle", bus.busy, 1'b0);
        chk("t3_resp1_held", bus.req1_resp, 2'b10);

        // Async reset while in S_BUSY.
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 64'h8000_0100;
        #1;
        tick();
        bus.req0_valid = 1'b0;
        tick();
        bus.eng_aw_ready = 1'b0;
        tick();
        chk("t5_in_busy", bus.busy, 1'b1);
        #2;
        reset_n = 1'b0;
        bus.eng_aw_ready = 1'b1;
        #1;
        chk("t5_busy", bus.busy, 1'b0);
        chk("t5_awvalid", bus.eng_aw_valid, 1'b0);
        chk("t5_addr", bus.eng_addr, 64'h0);
        chk("t5_grant", bus.grant, 1'b0);
        chk("t5_resp", {bus.req0_resp, bus.req1_resp}, 4'h0);
        chk("t5_done", {bus.req0_done, bus.req1_done}, 2'b00);
        chk("t5_ready", {bus.req0_ready, bus.req1_ready}, 2'b00);
        repeat (2) begin
            tick();
            chk("t5_nodone", {bus.req0_done, bus.req1_done}, 2'b00);
        end
        reset_n = 1'b1;
        tick();
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        chk("t5_ready0", bus.req0_ready, 1'b1);
        chk("t5_ready1", bus.req1_ready, 1'b0);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        chk("t5_grant0", bus.grant, 1'b0);
        engine_run(2'b00, 1, 64'h8000_0100);
        chk("t5_done0", bus.req0_done, 1'b1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
